lenet_layer_scheduler: RTL and testbench

- Top-level network sequencer for the LeNet-5 accelerator.
- Drives the per-layer enable levels (L1 conv, L2 pool, L3 conv+pool, L5/L6 FC) in fixed order and waits for each layer's done level.
- Uses the level handshake the layer wrappers implement: en held high until done; en dropped; wrapper returns to IDLE and drops done.
- Adds an inter-layer gap, a per-layer watchdog, abort, and a total cycle counter.

---
 rtl/lenet_layer_scheduler.sv | 178 +++++++++++++++++
 tb/tb_lenet_layer_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_layer_scheduler.sv
// lenet_layer_scheduler
// Network-level sequencer for the LeNet-5 accelerator. Walks the layer
// wrappers in fixed order using their level handshake (en held until done,
// en dropped, wait for done to fall), inserts an idle gap between layers,
// guards every layer with a watchdog and counts total busy cycles.
module lenet_layer_scheduler #(
  parameter int          NUM_LAYERS = 4,
  parameter int          IDX_W      = 3,
  parameter int          GAP_CYCLES = 2,
  parameter int          TO_W       = 20,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int          CNT_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [IDX_W-1:0]      cur_layer,
  output logic                  busy,
  output logic                  net_done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_layer,
  output logic [CNT_W-1:0]      total_cycles
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  // Gap counter only has to reach GAP_CYCLES-1; keep at least one bit so a
  // zero gap still elaborates (the GAP state is then unreachable).
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(NUM_LAYERS - 1);

  logic [2:0]            state_reg;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic [TO_W-1:0]       wd_cnt_reg;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_LAYERS-1:0] next_onehot;
  logic [NUM_LAYERS-1:0] done_hits;
  logic                  done_sel;
  logic                  is_last;
  logic                  wd_expired;
  logic                  cnt_active;

  // Only the active layer's done bit matters; the others are masked off
  // here so stray done levels can never advance the sequence.
  assign next_idx = cur_layer + IDX_W'(1);

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    assign done_hits[gi]   = layer_done[gi] & (cur_layer == IDX_W'(gi));
    assign next_onehot[gi] = (next_idx == IDX_W'(gi));
  end

  assign done_sel   = |done_hits;
  assign is_last    = (cur_layer == LAST_LAYER);
  assign wd_expired = (wd_cnt_reg == TO_LAST);
  assign cnt_active = (state_reg == S_RUN) || (state_reg == S_RELEASE) ||
                      (state_reg == S_GAP) || (state_reg == S_FINISH);

  // Sequencer FSM with registered outputs; abort outranks every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      layer_en     <= '0;
      cur_layer    <= '0;
      busy         <= 1'b0;
      net_done     <= 1'b0;
      err          <= 1'b0;
      err_layer    <= '0;
      total_cycles <= '0;
      gap_cnt_reg  <= '0;
      wd_cnt_reg   <= '0;
    end else if (abort) begin
      state_reg <= S_IDLE;
      layer_en  <= '0;
      busy      <= 1'b0;
      net_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      net_done <= 1'b0;
      // Saturating run-time counter; frozen outside the active states.
      if (cnt_active && (total_cycles != {CNT_W{1'b1}}))
        total_cycles <= total_cycles + CNT_W'(1);

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            layer_en     <= NUM_LAYERS'(1);
            cur_layer    <= '0;
            total_cycles <= '0;
            wd_cnt_reg   <= '0;
            busy         <= 1'b1;
            state_reg    <= S_RUN;
          end
        end

        S_RUN: begin
          // Done on the watchdog's last cycle still counts as success.
          if (done_sel) begin
            layer_en   <= '0;
            wd_cnt_reg <= wd_cnt_reg + TO_W'(1);
            state_reg  <= S_RELEASE;
          end else if (wd_expired) begin
            layer_en  <= '0;
            err       <= 1'b1;
            err_layer <= cur_layer;
            busy      <= 1'b0;
            state_reg <= S_ERROR;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + TO_W'(1);
          end
        end

        S_RELEASE: begin
          if (!done_sel) begin
            if (is_last) begin
              net_done  <= 1'b1;
              busy      <= 1'b0;
              state_reg <= S_FINISH;
            end else if (GAP_CYCLES == 0) begin
              layer_en   <= next_onehot;
              cur_layer  <= next_idx;
              wd_cnt_reg <= '0;
              state_reg  <= S_RUN;
            end else begin
              gap_cnt_reg <= '0;
              state_reg   <= S_GAP;
            end
          end else if (wd_expired) begin
            layer_en  <= '0;
            err       <= 1'b1;
            err_layer <= cur_layer;
            busy      <= 1'b0;
            state_reg <= S_ERROR;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + TO_W'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            layer_en   <= next_onehot;
            cur_layer  <= next_idx;
            wd_cnt_reg <= '0;
            state_reg  <= S_RUN;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        S_FINISH: begin
          state_reg <= S_IDLE;
        end

        S_ERROR: begin
          // Parked with enables low until abort or reset.
          layer_en <= '0;
        end

        default: begin
          layer_en  <= '0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// tb_lenet_layer_scheduler
// Directed bench: two schedulers share start/abort/rst; "a" runs with a
// 2-cycle gap, "b" with no gap. Behavioural layer models raise done 10
// cycles after en rises and drop it the cycle after en falls.
module tb_lenet_layer_scheduler;

  localparam int NL       = 4;
  localparam int DONE_LAT = 10;
  localparam int TR       = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [3:0]  done_a, done_b, en_a, en_b;
  logic [2:0]  cur_a, cur_b, errl_a, errl_b;
  logic        busy_a, busy_b, nd_a, nd_b, err_a, err_b;
  logic [23:0] tot_a, tot_b;

  logic [3:0]  kill_mask, force_mask;
  logic [3:0]  mdl_done [2];
  int          mdl_cnt  [2][4];
  logic [3:0]  en_v     [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] tr_en_a [TR];
  logic [3:0] tr_en_b [TR];
  logic       tr_nd_a [TR];
  logic       tr_nd_b [TR];
  logic       tr_err_a[TR];
  logic       tr_bsy_a[TR];

  lenet_layer_scheduler #(
    .NUM_LAYERS(4), .IDX_W(3), .GAP_CYCLES(2), .TO_W(20), .TIMEOUT(50), .CNT_W(24)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .layer_done(done_a), .layer_en(en_a), .cur_layer(cur_a), .busy(busy_a),
    .net_done(nd_a), .err(err_a), .err_layer(errl_a), .total_cycles(tot_a)
  );

  lenet_layer_scheduler #(
    .NUM_LAYERS(4), .IDX_W(3), .GAP_CYCLES(0), .TO_W(20), .TIMEOUT(50), .CNT_W(24)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .layer_done(done_b), .layer_en(en_b), .cur_layer(cur_b), .busy(busy_b),
    .net_done(nd_b), .err(err_b), .err_layer(errl_b), .total_cycles(tot_b)
  );

  assign en_v[0] = en_a;
  assign en_v[1] = en_b;
  assign done_a  = (mdl_done[0] & ~kill_mask) | force_mask;
  assign done_b  = mdl_done[1] & ~kill_mask;

  // Layer wrapper models: done rises after DONE_LAT enabled cycles, falls after en drops.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NL; i++) begin
        if (rst || !en_v[d][i]) begin
          mdl_cnt[d][i]  <= 0;
          mdl_done[d][i] <= 1'b0;
        end else begin
          mdl_cnt[d][i] <= mdl_cnt[d][i] + 1;
          if (mdl_cnt[d][i] + 1 >= DONE_LAT) mdl_done[d][i] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected enable at sample k after start: each layer has 11 enabled
  // cycles, 2 RELEASE cycles and g GAP cycles before the next one.
  function automatic logic [3:0] exp_en(input int k, input int g);
    int p, i, r;
    p = 13 + g;
    i = k / p;
    r = k % p;
    if (i < NL && r <= 10) return 4'(1 << i);
    return 4'd0;
  endfunction

  initial begin
    int mism_a, mism_b, nd_cnt_a, nd_cnt_b, nd_at_a, nd_at_b;
    int en_hits, nd_hits, busy_hits;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    kill_mask = 4'd0; force_mask = 4'd0;
    repeat (3) step();
    rst = 1'b0;

    // ---------------- reset state ----------------
    $display("[TB] step: reset state");
    check("rst_en",     32'(en_a),   0);
    check("rst_busy",   32'(busy_a), 0);
    check("rst_nd",     32'(nd_a),   0);
    check("rst_err",    32'(err_a),  0);
    check("rst_cur",    32'(cur_a),  0);
    check("rst_errl",   32'(errl_a), 0);
    check("rst_total",  32'(tot_a),  0);

    // ---------------- nominal run, both gap settings ----------------
    $display("[TB] step: nominal run gap=2 and gap=0");
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tr_en_a[k] = en_a; tr_en_b[k] = en_b;
      tr_nd_a[k] = nd_a; tr_nd_b[k] = nd_b;
      tr_bsy_a[k] = busy_a;
      step();
    end
    mism_a = 0; mism_b = 0; nd_cnt_a = 0; nd_cnt_b = 0; nd_at_a = -1; nd_at_b = -1;
    for (int k = 0; k < 70; k++) begin
      if (tr_en_a[k] !== exp_en(k, 2)) mism_a++;
      if (tr_en_b[k] !== exp_en(k, 0)) mism_b++;
      if (tr_nd_a[k] === 1'b1) begin nd_cnt_a++; nd_at_a = k; end
      if (tr_nd_b[k] === 1'b1) begin nd_cnt_b++; nd_at_b = k; end
    end
    check("g2_en_trace_mismatches", 32'(mism_a), 0);
    check("g2_en_first", 32'(tr_en_a[0]), 1);
    check("g2_en_l1_rise", 32'(tr_en_a[15]), 2);
    check("g2_en_gap_zero", 32'(tr_en_a[14]), 0);
    check("g2_en_l3_rise", 32'(tr_en_a[45]), 8);
    check("g2_netdone_count", 32'(nd_cnt_a), 1);
    check("g2_netdone_cycle", 32'(nd_at_a), 58);
    check("g2_total", 32'(tot_a), 59);
    check("g2_busy_run", 32'(tr_bsy_a[0]), 1);
    check("g2_busy_finish", 32'(tr_bsy_a[58]), 0);
    check("g2_busy_after", 32'(busy_a), 0);
    check("g2_cur_hold", 32'(cur_a), 3);
    check("g0_en_trace_mismatches", 32'(mism_b), 0);
    check("g0_en_l1_rise", 32'(tr_en_b[13]), 2);
    check("g0_en_before_rise", 32'(tr_en_b[12]), 0);
    check("g0_netdone_count", 32'(nd_cnt_b), 1);
    check("g0_netdone_cycle", 32'(nd_at_b), 52);
    check("g0_total", 32'(tot_b), 53);

    // ---------------- watchdog on layer 2 ----------------
    $display("[TB] step: layer 2 never completes, timeout 50");
    kill_mask = 4'b0100;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 86; k++) begin
      tr_en_a[k] = en_a; tr_err_a[k] = err_a;
      step();
    end
    check("to_en_last_run", 32'(tr_en_a[79]), 4);
    check("to_en_dropped", 32'(tr_en_a[80]), 0);
    check("to_err_before", 32'(tr_err_a[79]), 0);
    check("to_err_set", 32'(tr_err_a[80]), 1);
    check("to_err_layer", 32'(errl_a), 2);
    check("to_busy", 32'(busy_a), 0);
    $display("[TB] step: start while in error");
    start = 1'b1; step(); start = 1'b0; step(); step();
    check("err_start_ignored_en", 32'(en_a), 0);
    check("err_sticky", 32'(err_a), 1);
    $display("[TB] step: abort clears error");
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_err_clear", 32'(err_a), 0);
    check("abort_err_busy", 32'(busy_a), 0);
    check("abort_err_en", 32'(en_a), 0);
    kill_mask = 4'd0;
    step();
    start = 1'b1; step(); start = 1'b0;
    check("restart_after_abort", 32'(en_a), 1);
    abort = 1'b1; step(); abort = 1'b0; step();

    // ---------------- abort during gap ----------------
    $display("[TB] step: abort during gap after layer 1");
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 28; k++) step();
    check("gap_en_zero", 32'(en_a), 0);
    check("gap_busy", 32'(busy_a), 1);
    abort = 1'b1; step(); abort = 1'b0;
    en_hits = 0; nd_hits = 0; busy_hits = 0;
    for (int k = 0; k < 25; k++) begin
      if (en_a !== 4'd0) en_hits++;
      if (nd_a !== 1'b0) nd_hits++;
      if (busy_a !== 1'b0) busy_hits++;
      step();
    end
    check("gap_abort_en_cycles", 32'(en_hits), 0);
    check("gap_abort_netdone_cycles", 32'(nd_hits), 0);
    check("gap_abort_busy_cycles", 32'(busy_hits), 0);

    // ---------------- abort together with start ----------------
    $display("[TB] step: abort with start in idle");
    abort = 1'b1; start = 1'b1; step(); start = 1'b0; abort = 1'b0;
    check("abort_start_en", 32'(en_a), 0);
    check("abort_start_busy", 32'(busy_a), 0);
    step(); step();
    check("abort_start_en_later", 32'(en_a), 0);

    // ---------------- spurious done / pre-high done ----------------
    $display("[TB] step: spurious done[3], layer 1 done pre-high");
    force_mask = 4'b1010;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 26; k++) begin
      tr_en_a[k] = en_a; tr_bsy_a[k] = busy_a;
      if (k == 20) begin
        check("pre_release_busy", 32'(busy_a), 1);
        check("pre_release_cur", 32'(cur_a), 1);
        force_mask = 4'd0;
      end
      step();
    end
    check("spur_l0_start", 32'(tr_en_a[0]), 1);
    check("spur_l0_full", 32'(tr_en_a[10]), 1);
    check("spur_l0_drop", 32'(tr_en_a[11]), 0);
    check("pre_l1_en", 32'(tr_en_a[15]), 2);
    check("pre_l1_one_cycle", 32'(tr_en_a[16]), 0);
    check("pre_release_wait", 32'(tr_en_a[20]), 0);
    check("pre_gap_zero", 32'(tr_en_a[22]), 0);
    check("pre_l2_en", 32'(tr_en_a[23]), 4);
    abort = 1'b1; step(); abort = 1'b0; step();

    // ---------------- reset mid-run ----------------
    $display("[TB] step: reset during layer 1 run");
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check("rst_mid_en_before", 32'(en_a), 2);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid_en", 32'(en_a), 0);
    check("rst_mid_busy", 32'(busy_a), 0);
    check("rst_mid_cur", 32'(cur_a), 0);
    check("rst_mid_total", 32'(tot_a), 0);
    check("rst_mid_nd", 32'(nd_a), 0);
    check("rst_mid_err", 32'(err_a), 0);
    start = 1'b1; step(); start = 1'b0;
    check("rst_restart_en", 32'(en_a), 1);
    check("rst_restart_cur", 32'(cur_a), 0);
    check("rst_restart_busy", 32'(busy_a), 1);
    abort = 1'b1; step(); abort = 1'b0; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
